in_switch: RTL
==============

IN_SWITCH -- requirements
Module: in_switch

Interface
REQ-001 Parameter DWIDTH, default 128, data width of every stream port.
REQ-002 Parameter BURST_LEN, default 16, maximum beats per burst (2..256).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 mode  input  2  route select: 00 alternate, 01 port 0 only, 10 port 1 only, 11 broadcast.
REQ-006 s_axis_tdata  input  DWIDTH  input beat data.
REQ-007 s_axis_tvalid  input  1  input beat valid.
REQ-008 s_axis_tlast  input  1  early end of burst.
REQ-009 s_axis_tready  output  1  input beat accepted when high with tvalid.
REQ-010 m_axis_tdata_0 / m_axis_tvalid_0 / m_axis_tlast_0  output  DWIDTH/1/1  port 0 stream.
REQ-011 m_axis_tready_0  input  1  port 0 back-pressure.
REQ-012 m_axis_tdata_1 / m_axis_tvalid_1 / m_axis_tlast_1  output  DWIDTH/1/1  port 1 stream.
REQ-013 m_axis_tready_1  input  1  port 1 back-pressure.

Function
REQ-014 Block SHALL route each accepted input beat to port 0, port 1, or both, per the route latched for the current burst.
REQ-015 FSM SHALL have states IDLE (between bursts) and BURST.
REQ-016 In IDLE, route SHALL be computed from mode: 01 -> port 0; 10 -> port 1; 11 -> both; 00 -> port given by next_port register.
REQ-017 First accepted beat in IDLE SHALL latch the route and move to BURST, unless it is also the last beat (see REQ-019).
REQ-018 mode changes during BURST SHALL be ignored until return to IDLE.
REQ-019 Burst end SHALL occur on the accepted beat with beat_cnt == BURST_LEN-1 or s_axis_tlast == 1, whichever comes first; FSM returns to IDLE and beat_cnt clears to 0.
REQ-020 beat_cnt SHALL increment by 1 per accepted beat within a burst and never exceed BURST_LEN-1.
REQ-021 next_port SHALL toggle at every burst end whose latched mode was 00, and SHALL hold otherwise.
REQ-022 Each output tlast SHALL be 1 on the burst-end beat delivered to that port, else 0.
REQ-023 Each output port SHALL have a 2-entry skid buffer; m_axis_tvalid_x SHALL be driven directly from a register.
REQ-024 Latency SHALL be exactly 1 cycle from input acceptance to m_axis_tvalid_x high when that buffer is empty.
REQ-025 s_axis_tready SHALL be registered and SHALL be high only when every selected buffer holds at most one entry (broadcast: both).
REQ-026 Input acceptance in broadcast SHALL write both buffers in the same cycle; no beat SHALL reach only one port.
REQ-027 A buffer SHALL pop on m_axis_tvalid_x & m_axis_tready_x; simultaneous push and pop SHALL keep occupancy constant and preserve order.
REQ-028 Unselected port SHALL see no valid beats; its buffer contents remain undisturbed.
REQ-029 With sustained tvalid and both readies high, throughput SHALL be one beat per cycle in every mode.
REQ-030 Data order per port SHALL equal input acceptance order; no beat SHALL be dropped or duplicated.

Reset
REQ-031 On rst_n low: state IDLE, beat_cnt 0, next_port 0, both buffers empty.
REQ-032 During reset: s_axis_tready 0, m_axis_tvalid_0/1 0, m_axis_tlast_0/1 0, m_axis_tdata_0/1 0.
REQ-033 s_axis_tready SHALL rise on the first clk edge after rst_n deasserts.
REQ-034 Reset mid-burst SHALL discard buffered beats and the partial burst; no recovery of in-flight data.

Structure
REQ-035 Mode encodings (MODE_ALT, MODE_P0, MODE_P1, MODE_BCAST) and FSM state encodings SHALL live in the shared data_route package.
REQ-036 The skid buffer SHALL be a sub-module axis_skid (parameter DWIDTH, carries data+last), instantiated twice.

Verification
REQ-037 mode=00, BURST_LEN=4, 8 beats 0x1..0x8, readies high -> port 0 gets 1-4 (tlast on 4), port 1 gets 5-8 (tlast on 8).
REQ-038 mode=11, 3 beats with tlast on 3rd, m_axis_tready_1 low 5 cycles -> s_axis_tready drops after second buffered beat; both ports eventually emit identical 3 beats, tlast on 3rd.
REQ-039 mode=01, switch mode to 10 after beat 2 of a 16-beat burst -> all 16 beats on port 0; next burst goes to port 1.
REQ-040 mode=00, tlast on beat 2 of burst 1 -> burst 1 (2 beats) on port 0, following burst starts on port 1, beat_cnt restarts at 0.
REQ-041 Random tvalid/tready (50%) for 1000 beats all modes -> scoreboard per port: order preserved, no loss, no duplicates.
REQ-042 Assert rst_n low with 2 beats buffered on port 0 -> m_axis_tvalid_0 0 immediately; after release, next burst routes per mode with next_port 0.

Source files
------------

// File: rtl/data_route_pkg.sv
// rtl/data_route_pkg.sv - shared mode/state encodings and route helper for in_switch
package data_route_pkg;

  typedef enum logic [1:0] {
    MODE_ALT   = 2'b00,
    MODE_P0    = 2'b01,
    MODE_P1    = 2'b10,
    MODE_BCAST = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Route mask: bit 0 selects port 0, bit 1 selects port 1.
  function automatic logic [1:0] route_of(input mode_e m, input logic next_port);
    case (m)
      MODE_P0:    route_of = 2'b01;
      MODE_P1:    route_of = 2'b10;
      MODE_BCAST: route_of = 2'b11;
      default:    route_of = next_port ? 2'b10 : 2'b01;
    endcase
  endfunction

endpackage

// File: rtl/axis_skid.sv
// rtl/axis_skid.sv - 2-entry output buffer carrying data+last with registered valid
module axis_skid #(
  parameter int DWIDTH = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_push,
  input  logic [DWIDTH-1:0] s_tdata,
  input  logic              s_tlast,
  output logic [DWIDTH-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [1:0]        occ_next
);

  logic [DWIDTH:0] head_q, head_d;
  logic [DWIDTH:0] tail_q, tail_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            pop;
  logic [DWIDTH:0] in_beat;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    in_beat = {s_tlast, s_tdata};
    pop     = valid_q & m_tready;
    case (cnt_q)
      2'd0: begin
        if (s_push) begin
          head_d = in_beat;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        case ({s_push, pop})
          2'b10: begin
            tail_d = in_beat;
            cnt_d  = 2'd2;
          end
          2'b01: cnt_d = 2'd0;
          2'b11: head_d = in_beat;
          default: ;
        endcase
      end
      default: begin
        // Full: the upstream registered ready guarantees no push without a pop here.
        if (pop) begin
          head_d = tail_q;
          if (s_push) tail_d = in_beat;
          else        cnt_d  = 2'd1;
        end
      end
    endcase
    valid_d  = (cnt_d != 2'd0);
    occ_next = cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign m_tdata  = head_q[DWIDTH-1:0];
  assign m_tlast  = head_q[DWIDTH];
  assign m_tvalid = valid_q;

endmodule

// File: rtl/in_switch.sv
// rtl/in_switch.sv - burst-granular 1-to-2 stream router with per-port skid buffers
module in_switch
  import data_route_pkg::*;
#(
  parameter int DWIDTH    = 128,
  parameter int BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DWIDTH-1:0] m_axis_tdata_0,
  output logic              m_axis_tvalid_0,
  output logic              m_axis_tlast_0,
  input  logic              m_axis_tready_0,
  output logic [DWIDTH-1:0] m_axis_tdata_1,
  output logic              m_axis_tvalid_1,
  output logic              m_axis_tlast_1,
  input  logic              m_axis_tready_1
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          next_port_q, next_port_d;
  logic [1:0]    route_q, route_d;
  logic          alt_q, alt_d;
  mode_e         mode_q, mode_d;
  logic          ready_q, ready_d;

  logic [1:0] cur_route, next_route, push;
  logic       cur_alt, accept, burst_end;
  logic [1:0] occ_next_0, occ_next_1;

  // mode is sampled so the registered ready is precomputed against the same route used at acceptance.
  always_comb begin
    mode_d      = mode_e'(mode);
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    next_port_d = next_port_q;
    route_d     = route_q;
    alt_d       = alt_q;
    cur_route   = (state_q == ST_IDLE) ? route_of(mode_q, next_port_q) : route_q;
    cur_alt     = (state_q == ST_IDLE) ? (mode_q == MODE_ALT) : alt_q;
    accept      = s_axis_tvalid & ready_q;
    burst_end   = accept & (s_axis_tlast | (beat_cnt_q == LAST_CNT));
    push        = accept ? cur_route : 2'b00;
    if (accept) begin
      if (burst_end) begin
        state_d    = ST_IDLE;
        beat_cnt_d = '0;
        if (cur_alt) next_port_d = ~next_port_q;
      end else begin
        state_d    = ST_BURST;
        beat_cnt_d = beat_cnt_q + CW'(1);
        route_d    = cur_route;
        alt_d      = cur_alt;
      end
    end
  end

  always_comb begin
    next_route = (state_d == ST_BURST) ? route_d : route_of(mode_d, next_port_d);
    ready_d    = (!next_route[0] || (occ_next_0 <= 2'd1)) &&
                 (!next_route[1] || (occ_next_1 <= 2'd1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      next_port_q <= 1'b0;
      route_q     <= 2'b00;
      alt_q       <= 1'b0;
      mode_q      <= MODE_ALT;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      next_port_q <= next_port_d;
      route_q     <= route_d;
      alt_q       <= alt_d;
      mode_q      <= mode_d;
      ready_q     <= ready_d;
    end
  end

  assign s_axis_tready = ready_q;

  axis_skid #(.DWIDTH(DWIDTH)) u_skid_0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_push   (push[0]),
    .s_tdata  (s_axis_tdata),
    .s_tlast  (burst_end),
    .m_tdata  (m_axis_tdata_0),
    .m_tvalid (m_axis_tvalid_0),
    .m_tlast  (m_axis_tlast_0),
    .m_tready (m_axis_tready_0),
    .occ_next (occ_next_0)
  );

  axis_skid #(.DWIDTH(DWIDTH)) u_skid_1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_push   (push[1]),
    .s_tdata  (s_axis_tdata),
    .s_tlast  (burst_end),
    .m_tdata  (m_axis_tdata_1),
    .m_tvalid (m_axis_tvalid_1),
    .m_tlast  (m_axis_tlast_1),
    .m_tready (m_axis_tready_1),
    .occ_next (occ_next_1)
  );

endmodule
